// File: rtl/gpreg_file_pkg.sv
// gpreg_file_pkg: shared types and helpers for the general-purpose register file.
//   idx_width()   - register index width, clog2 with a minimum of 1
//   FLAGS_RESET   - flags reset value (all ones, truncated to FLAG_WIDTH by users)
//   pend_entry_t  - pending-write entry {valid, idx, data}, sized for the
//                   largest legal configuration (16 registers, 64-bit data)
package gpreg_file_pkg;

    localparam int unsigned MAX_IDX_W  = 4;
    localparam int unsigned MAX_DATA_W = 64;

    localparam logic [31:0] FLAGS_RESET = '1;

    typedef struct packed {
        logic                  valid;
        logic [MAX_IDX_W-1:0]  idx;
        logic [MAX_DATA_W-1:0] data;
    } pend_entry_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/gpreg_file_pending.sv
// gpreg_file_pending: one-entry pending-write buffer.
// A write accepted on an edge is held here for exactly one cycle; the entry
// is committed to the register array on the following edge.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr_valid    - accepted (in-range) write request
//   wr_idx      - destination index, zero-extended
//   wr_data     - write data, zero-extended
//   pend        - current pending entry (registered)
//   commit_c    - entry is committed to the array on the next edge
module gpreg_file_pending
    import gpreg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [MAX_IDX_W-1:0]  wr_idx,
    input  logic [MAX_DATA_W-1:0] wr_data,
    output pend_entry_t           pend,
    output logic                  commit_c
);

    // Valid tracks every edge; payload only reloads on a new write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend.valid <= wr_valid;
            if (wr_valid) begin
                pend.idx  <= wr_idx;
                pend.data <= wr_data;
            end
        end
    end

    assign commit_c = pend.valid;

endmodule

// File: rtl/gpreg_file.sv
// gpreg_file: parametrised general-purpose register file with ALU flags.
// Writes land in a one-entry pending stage and commit on the next edge.
// Build option GPREG_FILE_BYPASS_EN:
//   defined   - reads forward from the pending stage, STALL tied 0
//   undefined - reads see the array only; STALL flags a read of the
//               pending index so the sequencer holds one cycle
// Ports:
//   CLK, RST_bar                 - clock, asynchronous active-low reset
//   WR_EN, WR_INDEX, WR_DATA     - write request (out-of-range index ignored)
//   LHS_INDEX/LHS_OUT            - LHS read port
//   RHS_INDEX/RHS_OUT            - RHS read port
//   MAIN_INDEX/MAIN_OE/MAIN_OUT  - main-bus read port, zero when MAIN_OE=0
//   FLAGS_LOAD, FLAGS_IN         - flags load
//   FLAGS_OUT                    - flags register (resets to all ones)
//   STALL                        - read-after-write hazard (no-bypass build)
// Read ports and STALL are combinational from state and index inputs.
// DELAY_RISE/DELAY_FALL are simulation-only output delays; the synthesizable
// model has no delays, so they are accepted and ignored. DATA_WIDTH <= 64.
module gpreg_file
    import gpreg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned FLAG_WIDTH = 2,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0
) (
    input  logic                             CLK,
    input  logic                             RST_bar,
    input  logic                             WR_EN,
    input  logic [idx_width(NUM_REGS)-1:0]   WR_INDEX,
    input  logic [DATA_WIDTH-1:0]            WR_DATA,
    input  logic [idx_width(NUM_REGS)-1:0]   LHS_INDEX,
    input  logic [idx_width(NUM_REGS)-1:0]   RHS_INDEX,
    input  logic [idx_width(NUM_REGS)-1:0]   MAIN_INDEX,
    input  logic                             MAIN_OE,
    output logic [DATA_WIDTH-1:0]            LHS_OUT,
    output logic [DATA_WIDTH-1:0]            RHS_OUT,
    output logic [DATA_WIDTH-1:0]            MAIN_OUT,
    input  logic                             FLAGS_LOAD,
    input  logic [FLAG_WIDTH-1:0]            FLAGS_IN,
    output logic [FLAG_WIDTH-1:0]            FLAGS_OUT,
    output logic                             STALL
);

    localparam int unsigned IDX_W = idx_width(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    pend_entry_t           pend;
    logic                  commit_c;
    logic                  wr_accept_c;
    logic                  pend_valid;
    logic [IDX_W-1:0]      pend_idx;
    logic [DATA_WIDTH-1:0] pend_data;

    logic [IDX_W-1:0]      rd_idx  [3];
    logic [DATA_WIDTH-1:0] rd_data [3];

    // Delay parameters have no synthesizable meaning.
    if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_sim_delay_ignored
    end

    // Out-of-range indices (non-power-of-two NUM_REGS) never reach the array.
    assign wr_accept_c = WR_EN && (32'(WR_INDEX) < NUM_REGS);

    gpreg_file_pending u_pending (
        .clk      (CLK),
        .rst_n    (RST_bar),
        .wr_valid (wr_accept_c),
        .wr_idx   (MAX_IDX_W'(WR_INDEX)),
        .wr_data  (MAX_DATA_W'(WR_DATA)),
        .pend     (pend),
        .commit_c (commit_c)
    );

    assign pend_valid = pend.valid;
    assign pend_idx   = pend.idx[IDX_W-1:0];
    assign pend_data  = pend.data[DATA_WIDTH-1:0];

    // Upper struct bits beyond this configuration are structurally zero.
    logic unused_pend;
    assign unused_pend = ^pend;

    // Commit the pending entry into the array.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_c) begin
            regs[pend_idx] <= pend_data;
        end
    end

    // Read ports: 0 = LHS, 1 = RHS, 2 = MAIN.
    always_comb begin
        rd_idx[0] = LHS_INDEX;
        rd_idx[1] = RHS_INDEX;
        rd_idx[2] = MAIN_INDEX;
        for (int unsigned p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (32'(rd_idx[p]) < NUM_REGS) begin
                rd_data[p] = regs[rd_idx[p]];
            end
`ifdef GPREG_FILE_BYPASS_EN
            if (pend_valid && (rd_idx[p] == pend_idx)) begin
                rd_data[p] = pend_data;
            end
`endif
        end
    end

    assign LHS_OUT  = rd_data[0];
    assign RHS_OUT  = rd_data[1];
    assign MAIN_OUT = MAIN_OE ? rd_data[2] : '0;

`ifdef GPREG_FILE_BYPASS_EN
    assign STALL = 1'b0;
`else
    // Any active read of the not-yet-committed index must wait one cycle.
    assign STALL = pend_valid &&
                   ((LHS_INDEX == pend_idx) ||
                    (RHS_INDEX == pend_idx) ||
                    (MAIN_OE && (MAIN_INDEX == pend_idx)));
`endif

    // Flags register, independent of the register write path.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            FLAGS_OUT <= FLAG_WIDTH'(FLAGS_RESET);
        end else if (FLAGS_LOAD) begin
            FLAGS_OUT <= FLAGS_IN;
        end
    end

endmodule
